// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU operation classes and ALU control words.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the 3-bit ALU control word.
module mips_aludec
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes fall back to ADD so the datapath simply writes a sum.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore multicycle control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, driving datapath selects and enables.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;
  logic   branchne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state controls; op only steers transitions and illegal_op.
  always_comb begin
    state_d    = S_FETCH;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE: begin
            if (ENABLE_BNE) begin
              state_d = S_BNEEX;
            end else begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branchne = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench: two controllers (bne enabled / disabled) run instruction
// streams against a per-instruction step-table model of the control outputs.
module tb_mips_mc_controller;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ILL   = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b, zero;
  logic [5:0] op_a, op_b, funct;
  logic       pcen_a, memwrite_a, irwrite_a, regwrite_a, iord_a, memtoreg_a, regdst_a, alusrca_a, illegal_a;
  logic       pcen_b, memwrite_b, irwrite_b, regwrite_b, iord_b, memtoreg_b, regdst_b, alusrca_b, illegal_b;
  logic [1:0] alusrcb_a, pcsrc_a, alusrcb_b, pcsrc_b;
  logic [2:0] aluc_a, aluc_b;
  logic [15:0] obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;
  int step_a = 0;
  int step_b = 0;
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  bit rnd_en = 1'b0;

  mips_mc_controller #(.ENABLE_BNE(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .funct(funct), .zero(zero),
    .pcen(pcen_a), .memwrite(memwrite_a), .irwrite(irwrite_a), .regwrite(regwrite_a),
    .iord(iord_a), .memtoreg(memtoreg_a), .regdst(regdst_a), .alusrca(alusrca_a),
    .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .alucontrol(aluc_a), .illegal_op(illegal_a)
  );

  mips_mc_controller #(.ENABLE_BNE(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .funct(funct), .zero(zero),
    .pcen(pcen_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regwrite(regwrite_b),
    .iord(iord_b), .memtoreg(memtoreg_b), .regdst(regdst_b), .alusrca(alusrca_b),
    .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .alucontrol(aluc_b), .illegal_op(illegal_b)
  );

  assign obs_a = {pcen_a, memwrite_a, irwrite_a, regwrite_a, iord_a, memtoreg_a, regdst_a,
                  alusrca_a, alusrcb_a, pcsrc_a, aluc_a, illegal_a};
  assign obs_b = {pcen_b, memwrite_b, irwrite_b, regwrite_b, iord_b, memtoreg_b, regdst_b,
                  alusrca_b, alusrcb_b, pcsrc_b, aluc_b, illegal_b};

  function automatic logic [5:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: return T_LW;
      1: return T_SW;
      2: return T_RTYPE;
      3: return T_BEQ;
      4: return T_BNE;
      5: return T_ADDI;
      6: return T_J;
      7: return T_ILL;
      default: return r[5:0];
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return r[5:0];
    endcase
  endfunction

  // Cycles per instruction, fetch included.
  function automatic int inst_len(bit en, logic [5:0] op);
    case (op)
      T_LW:                   return 5;
      T_SW, T_RTYPE, T_ADDI:  return 4;
      T_BEQ, T_J:             return 3;
      T_BNE:                  return en ? 3 : 2;
      default:                return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output vector for cycle 'step' of an instruction.
  function automatic logic [15:0] expect_out(bit en, logic [5:0] op, logic [5:0] f, logic z, int step);
    logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, ill;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, ill} = 9'd0;
    alusrcb = 2'b00;
    pcsrc   = 2'b00;
    aluc    = 3'b010;
    if (step == 0) begin
      alusrcb = 2'b01; irwrite = 1'b1; pcen = 1'b1;
    end else if (step == 1) begin
      alusrcb = 2'b11; ill = (inst_len(en, op) == 2);
    end else begin
      case (op)
        T_LW, T_SW: begin
          if (step == 2) begin
            alusrca = 1'b1; alusrcb = 2'b10;
          end else if (step == 3) begin
            iord = 1'b1; memwrite = (op == T_SW);
          end else begin
            memtoreg = 1'b1; regwrite = 1'b1;
          end
        end
        T_RTYPE: begin
          if (step == 2) begin
            alusrca = 1'b1; aluc = funct_alu(f);
          end else begin
            regdst = 1'b1; regwrite = 1'b1;
          end
        end
        T_ADDI: begin
          if (step == 2) begin
            alusrca = 1'b1; alusrcb = 2'b10;
          end else begin
            regwrite = 1'b1;
          end
        end
        T_BEQ, T_BNE: begin
          alusrca = 1'b1; aluc = 3'b110; pcsrc = 2'b01;
          pcen = (op == T_BEQ) ? z : ~z;
        end
        T_J: begin
          pcsrc = 2'b10; pcen = 1'b1;
        end
        default: ;
      endcase
    end
    return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluc, ill};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check both DUTs mid-cycle, then advance the model past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    check($sformatf("a op=%b step=%0d", op_a, step_a), obs_a, expect_out(1'b1, op_a, funct, zero, step_a));
    check($sformatf("b op=%b step=%0d", op_b, step_b), obs_b, expect_out(1'b0, op_b, funct, zero, step_b));
    @(posedge clk);
    #1;
    if (reset_a) begin
      step_a = 0;
    end else begin
      step_a++;
      if (step_a >= inst_len(1'b1, op_a)) begin
        step_a = 0;
        op_a = (q_a.size() != 0) ? q_a.pop_front() : rand_op();
      end
    end
    if (reset_b) begin
      step_b = 0;
    end else begin
      step_b++;
      if (step_b >= inst_len(1'b0, op_b)) begin
        step_b = 0;
        op_b = (q_b.size() != 0) ? q_b.pop_front() : rand_op();
      end
    end
    if (rnd_en) begin
      zero  = 1'($urandom_range(0, 1));
      funct = rand_funct();
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while ((q_a.size() != 0 || step_a != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    vectors++;
    assert (n < max_cycles) else begin
      miscompares++;
      $error("FAIL idle_timeout: observed %0d cycles required under %0d", n, max_cycles);
    end
  endtask

  initial begin
    int n;
    reset_a = 1'b1;
    reset_b = 1'b1;
    zero    = 1'b0;
    funct   = 6'b101010;
    op_a    = T_LW;
    op_b    = T_BNE;
    q_b.push_back(T_ILL);

    // Outputs during reset hold the FETCH values.
    repeat (2) cycle();
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Reset pulse in the middle of FETCH, then walk lw, sw, R-type slt, j.
    #2 reset_a = 1'b1;
    #1 check("reset_mid_fetch", obs_a, expect_out(1'b1, T_LW, funct, zero, 0));
    reset_a = 1'b0;
    q_a.push_back(T_SW);
    q_a.push_back(T_RTYPE);
    q_a.push_back(T_J);
    q_a.push_back(T_ADDI);
    run_until_idle(40);

    // Reset while in MEMWB: regwrite must drop immediately.
    q_a.push_back(T_LW);
    n = 0;
    while (!(op_a == T_LW && step_a == 4) && n < 40) begin
      cycle();
      n++;
    end
    check("reach_memwb", {15'd0, regwrite_a}, {15'd0, 1'b1});
    reset_a = 1'b1;
    #1 check("reset_memwb_regwrite", {15'd0, regwrite_a}, 16'd0);
    check("reset_memwb_fetch", obs_a, expect_out(1'b1, op_a, funct, zero, 0));
    reset_a = 1'b0;
    step_a = 0;
    run_until_idle(20);

    // Unknown funct decodes as ADD.
    funct = 6'b000000;
    q_a.push_back(T_RTYPE);
    run_until_idle(20);

    // Branches with zero set and clear.
    zero = 1'b1;
    q_a.push_back(T_BEQ);
    q_a.push_back(T_BNE);
    q_b.push_back(T_BNE);
    run_until_idle(20);
    zero = 1'b0;
    q_a.push_back(T_BEQ);
    q_a.push_back(T_BNE);
    q_b.push_back(T_BNE);
    run_until_idle(20);

    // Randomized instruction streams, funct and zero.
    rnd_en = 1'b1;
    repeat (500) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
